// File: rtl/sram_mem_responder.sv
// sram_mem_responder: MEM-stage load/store responder for a 16-bit asynchronous SRAM.
// Each 32-bit request is served as a low half-word access followed by a high
// half-word access, each WAIT_CYCLES clocks long. `ready` is held low for the
// whole transaction so the pipeline stays frozen.
// Optional feature macro: SRAM_READ_HIT_EN. When it is defined, a one-entry tag
// lets a repeated read of the last-read word complete in IDLE without an SRAM access.
module sram_mem_responder #(
    parameter int ADDR_OFFSET = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int WIDX_W = SRAM_AW - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_is_wr;
    logic [WIDX_W-1:0]   r_widx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;

    logic [31:0]         w_offset;
    logic [WIDX_W-1:0]   w_req_widx;
    logic                w_unused_addr;
    logic                w_last;
    logic                w_hit;
    logic                w_start;
    logic                w_dq_oe;
    logic [15:0]         w_dq_out;

    // Word index of the incoming request: offset removed modulo 2^32, byte lanes dropped.
    assign w_offset      = address - 32'(ADDR_OFFSET);
    assign w_req_widx    = w_offset[SRAM_AW:2];
    assign w_unused_addr = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

    // Last cycle of the current half-word phase.
    assign w_last = (r_cnt == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_READ_HIT_EN
    logic              r_tag_valid;
    logic [WIDX_W-1:0] r_tag_widx;

    // A read of the word fetched by the last completed read needs no SRAM access;
    // a write (including one with both enables set) never hits.
    assign w_hit = rd_en & ~wr_en & r_tag_valid & (r_tag_widx == w_req_widx);

    // Tag tracks the last completed read; a write to the same word invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_valid <= 1'b0;
            r_tag_widx  <= '0;
        end else if (r_state == S_DONE && !r_is_wr) begin
            r_tag_valid <= 1'b1;
            r_tag_widx  <= r_widx;
        end else if (r_state == S_IDLE && w_start && wr_en && (w_req_widx == r_tag_widx)) begin
            r_tag_valid <= 1'b0;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_start = (rd_en | wr_en) & ~w_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> LO -> HI -> DONE -> IDLE, phases timed by r_cnt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_LO;
            S_LO:    if (w_last)  w_state_nxt = S_HI;
            S_HI:    if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: handshake and SRAM strobes as a function of state and phase count.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ready     = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = {r_widx, 1'b0};
        w_dq_oe   = 1'b0;
        w_dq_out  = r_wdata[15:0];
        case (r_state)
            S_IDLE: begin
                ready = w_hit | ~(rd_en | wr_en);
            end
            S_LO: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = r_is_wr;
                // WE_N rises on the last cycle while data is still driven (hold time).
                SRAM_WE_N = ~r_is_wr | w_last;
                w_dq_oe   = r_is_wr;
            end
            S_HI: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = r_is_wr;
                SRAM_WE_N = ~r_is_wr | w_last;
                SRAM_ADDR = {r_widx, 1'b1};
                w_dq_oe   = r_is_wr;
                w_dq_out  = r_wdata[31:16];
            end
            S_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Datapath: latch the request in IDLE, time each phase, capture read halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_widx  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_is_wr <= wr_en;
                        r_widx  <= w_req_widx;
                        r_wdata <= writeData;
                    end
                end
                S_LO, S_HI: begin
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                    if (!r_is_wr && w_last) begin
                        if (r_state == S_LO) begin
                            r_rdata[15:0]  <= SRAM_DQ;
                        end else begin
                            r_rdata[31:16] <= SRAM_DQ;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign readData  = r_rdata;
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
